// File: rtl/urv_sram_bp.sv
// Single-port SRAM front end with a request/response handshake. A bypass path returns data one
// cycle after acceptance; a small FIFO catches responses that the consumer is not yet taking.
package urv_sram_bp_pkg;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_ADDR_W = 32;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef struct packed {
    mem_type_e                 req_type;
    logic [MEM_ADDR_W-1:0]     req_addr;
    logic [MEM_DATA_W-1:0]     req_data;
    logic [MEM_DATA_W/8-1:0]   req_mask;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0]     resp_data;
    mem_type_e                 resp_type;
    logic                      resp_last;
  } mem_resp_t;
endpackage

// Byte-lane SRAM, one registered read port; csn/wen/web are active-low.
module fast_sram_sp #(
  parameter int N_DW = 32,
  parameter int N_DP = 2048
) (
  input  logic                      clk,
  input  logic                      csn,
  input  logic                      wen,
  input  logic [N_DW/8-1:0]         web,
  input  logic [$clog2(N_DP)-1:0]   addr,
  input  logic [N_DW-1:0]           din,
  output logic [N_DW-1:0]           dout
);
  for (genvar gi = 0; gi < N_DW/8; gi++) begin : g_lane
    logic [7:0] mem [N_DP];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (!csn) begin
        if (!wen && !web[gi]) begin
          mem[addr] <= din[gi*8 +: 8];
        end
        rd_q <= mem[addr];
      end
    end

    assign dout[gi*8 +: 8] = rd_q;
  end
endmodule

module urv_sram_bp
  import urv_sram_bp_pkg::*;
#(
  parameter int WORDS      = 2048,
  parameter int RESP_DEPTH = 2,
  parameter bit WR_RESP    = 1'b1
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      mem_req_valid,
  output logic      mem_req_ready,
  input  mem_req_t  mem_req,
  output logic      mem_resp_valid,
  input  logic      mem_resp_ready,
  output mem_resp_t mem_resp
);
  localparam int AW = $clog2(WORDS);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int BW = MEM_DATA_W / 8;
  localparam logic [CW-1:0] CNT_MAX  = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(RESP_DEPTH - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  mem_type_e             inflight_type_q, inflight_type_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MEM_DATA_W-1:0] fifo_data_q [RESP_DEPTH];
  mem_type_e             fifo_type_q [RESP_DEPTH];

  logic                  req_fire, resp_fire, resp_gen;
  logic                  fifo_empty, fifo_push, fifo_pop, use_bypass;
  logic [MEM_DATA_W-1:0] sram_dout, inflight_data;
  logic                  sram_csn, sram_wen;
  logic [BW-1:0]         sram_web;
  logic                  addr_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Ready depends only on the counter so no combinational path reaches back from either handshake.
  assign mem_req_ready = (cnt_q < CNT_MAX);

  always_comb begin
    req_fire       = rstn && mem_req_valid && mem_req_ready;
    resp_gen       = req_fire && ((mem_req.req_type == MEM_READ) || WR_RESP);
    fifo_empty     = (cnt_q == CW'(inflight_q));
    use_bypass     = fifo_empty && inflight_q;
    mem_resp_valid = inflight_q || !fifo_empty;
    resp_fire      = mem_resp_valid && mem_resp_ready;
    inflight_data  = (inflight_type_q == MEM_WRITE) ? '0 : sram_dout;
    // The SRAM output is only valid for one cycle, so anything not taken straight off the bypass is parked.
    fifo_push      = inflight_q && !(use_bypass && mem_resp_ready);
    fifo_pop       = !fifo_empty && mem_resp_ready;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({resp_gen, resp_fire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    inflight_d      = resp_gen;
    inflight_type_d = resp_gen ? mem_req.req_type : inflight_type_q;
    wptr_d          = fifo_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d          = fifo_pop  ? ptr_inc(rptr_q) : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_type_q <= MEM_READ;
      wptr_q          <= '0;
      rptr_q          <= '0;
    end else begin
      cnt_q           <= cnt_d;
      inflight_q      <= inflight_d;
      inflight_type_q <= inflight_type_d;
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data_q[wptr_q] <= inflight_data;
      fifo_type_q[wptr_q] <= inflight_type_q;
    end
  end

  // The FIFO head always precedes the in-flight access, so it wins when both exist.
  always_comb begin
    mem_resp = '0;
    if (!fifo_empty) begin
      mem_resp.resp_data = fifo_data_q[rptr_q];
      mem_resp.resp_type = fifo_type_q[rptr_q];
      mem_resp.resp_last = 1'b1;
    end else if (use_bypass) begin
      mem_resp.resp_data = inflight_data;
      mem_resp.resp_type = inflight_type_q;
      mem_resp.resp_last = 1'b1;
    end
  end

  assign sram_csn    = ~req_fire;
  assign sram_wen    = ~(req_fire && (mem_req.req_type == MEM_WRITE));
  assign sram_web    = ~mem_req.req_mask;
  assign addr_unused = ^{mem_req.req_addr[MEM_ADDR_W-1:AW+2], mem_req.req_addr[1:0]};

  fast_sram_sp #(
    .N_DW (MEM_DATA_W),
    .N_DP (WORDS)
  ) u_sram (
    .clk  (clk),
    .csn  (sram_csn),
    .wen  (sram_wen),
    .web  (sram_web),
    .addr (mem_req.req_addr[AW+1:2]),
    .din  (mem_req.req_data),
    .dout (sram_dout)
  );

  a_cnt_bound : assert property (@(posedge clk) disable iff (!rstn) cnt_q <= CNT_MAX);
endmodule
